// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-store writer: word width, the
// end-of-program encoding and the loader FSM states.
package instr_loader_pkg;

  localparam int unsigned INSTR_W = 9;

  // End-of-program word; the control decoder decodes the same value as Ack.
  localparam logic [INSTR_W-1:0] ACK_WORD = 9'h1FF;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WR,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int unsigned A = 10
);

  logic               start;
  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_ready;
  logic               wr_en;
  logic [A-1:0]       wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               busy;
  logic               done;
  logic               err;
  logic [A:0]         word_count;

  // Loader side
  modport master (
    input  start, in_byte, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err, word_count
  );

  // Byte source / memory / core side
  modport slave (
    output start, in_byte, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, word_count
  );

endinterface

// File: rtl/instr_loader.sv
// Packs low/high byte pairs into 9-bit words and writes them sequentially
// into instruction memory until the end-of-program word or overflow.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned A = 10
) (
  input  logic           clk,
  input  logic           rst,
  instr_loader_if.master bus
);

  localparam int unsigned DEPTH     = 2 ** A;
  localparam logic [A-1:0] LAST_ADDR = A'(DEPTH - 1);

  loader_state_t state;
  logic [A-1:0]  addr;
  logic [7:0]    lo_byte;

  // Single-process FSM; every output is updated alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      lo_byte        <= '0;
      bus.in_ready   <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.word_count <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            state          <= LO;
            addr           <= '0;
            bus.word_count <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.busy       <= 1'b1;
            bus.in_ready   <= 1'b1;
          end
        end
        LO: begin
          if (bus.in_valid) begin
            lo_byte <= bus.in_byte;
            state   <= HI;
          end
        end
        HI: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (bus.in_byte[7:1] != 7'd0) begin
              // Malformed high byte: the word is dropped, nothing is written.
              state    <= ERR;
              bus.err  <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state       <= WR;
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= addr;
              bus.wr_data <= {bus.in_byte[0], lo_byte};
            end
          end
        end
        WR: begin
          bus.word_count <= bus.word_count + (A + 1)'(1);
          // Hold the address at the top rather than wrap; the load ends there anyway.
          if (addr != LAST_ADDR) begin
            addr <= addr + A'(1);
          end
          if (bus.wr_data == ACK_WORD) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else if (addr == LAST_ADDR) begin
            state    <= ERR;
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state        <= LO;
            bus.in_ready <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a full-size instance and a DEPTH=4
// instance share one byte stream so the overflow path can be exercised.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_byte;
  logic       in_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  instr_loader_if #(.A(10)) bus ();
  instr_loader_if #(.A(2))  bus_s ();

  assign bus.start      = start;
  assign bus.in_byte    = in_byte;
  assign bus.in_valid   = in_valid;
  assign bus_s.start    = start;
  assign bus_s.in_byte  = in_byte;
  assign bus_s.in_valid = in_valid;

  instr_loader #(.A(10)) dut   (.clk(clk), .rst(rst), .bus(bus.master));
  instr_loader #(.A(2))  dut_s (.clk(clk), .rst(rst), .bus(bus_s.master));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t wq[$];
  wr_t wqs[$];

  always @(negedge clk) begin
    if (bus.wr_en)   wq.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
    if (bus_s.wr_en) wqs.push_back('{int'(bus_s.wr_addr), int'(bus_s.wr_data)});
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
      if (bus.busy && !bus.wr_en) chk("ready_in_lo_hi", bus.in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    acc      = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("byte_accept_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       bad;
    logic [8:0] word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h10, 8'h03, 1'b1, 9'h000};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[2] = '{8'h10, 8'h02, 1'b1, 9'h000};
    vecs[3] = '{8'hAB, 8'h01, 1'b0, 9'h1AB};
    vecs[4] = '{8'h10, 8'h80, 1'b1, 9'h000};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 9'h1FF};
    vecs[6] = '{8'h7F, 8'h00, 1'b0, 9'h07F};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 9'h0FF};

    rst = 1'b1; start = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_wc", bus.word_count, 0);
    chk("rst_wr_en", bus.wr_en, 0);

    // Two-word program, InValid held high
    wq.delete();
    pulse_start();
    chk("start_busy", bus.busy, 1);
    send_byte(8'h25, 0);
    send_byte(8'h01, 0);
    chk("latency_wr_en", bus.wr_en, 1);
    chk("latency_wr_data", bus.wr_data, 9'h125);
    send_byte(8'hFF, 0);
    send_byte(8'h01, 0);
    idle(3);
    chk("basic_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("basic_a0", wq[0].addr, 0);
      chk("basic_d0", wq[0].data, 9'h125);
      chk("basic_a1", wq[1].addr, 1);
      chk("basic_d1", wq[1].data, 9'h1FF);
    end
    chk("basic_done", bus.done, 1);
    chk("basic_wc", bus.word_count, 2);
    chk("basic_busy", bus.busy, 0);
    chk("basic_in_ready", bus.in_ready, 0);

    // Same program with 3 idle cycles before every byte
    wq.delete();
    pulse_start();
    send_byte(8'h25, 3);
    send_byte(8'h01, 3);
    send_byte(8'hFF, 3);
    send_byte(8'h01, 3);
    idle(5);
    chk("gap_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("gap_d0", wq[0].data, 9'h125);
      chk("gap_a1", wq[1].addr, 1);
      chk("gap_d1", wq[1].data, 9'h1FF);
    end
    chk("gap_done", bus.done, 1);
    chk("gap_wc", bus.word_count, 2);

    // Single-word vectors; good non-end words are followed by the end word
    for (int i = 0; i < 8; i++) begin
      wq.delete();
      pulse_start();
      chk($sformatf("v%0d_err_clr", i), bus.err, 0);
      chk($sformatf("v%0d_done_clr", i), bus.done, 0);
      send_byte(vecs[i].lo, 0);
      send_byte(vecs[i].hi, 0);
      idle(3);
      if (vecs[i].bad) begin
        chk($sformatf("v%0d_err", i), bus.err, 1);
        chk($sformatf("v%0d_nwr", i), wq.size(), 0);
        chk($sformatf("v%0d_wc", i), bus.word_count, 0);
        chk($sformatf("v%0d_busy", i), bus.busy, 0);
      end else begin
        if (vecs[i].word != ACK_WORD) begin
          send_byte(8'hFF, 0);
          send_byte(8'h01, 0);
          idle(3);
          chk($sformatf("v%0d_wc", i), bus.word_count, 2);
        end else begin
          chk($sformatf("v%0d_wc", i), bus.word_count, 1);
        end
        chk($sformatf("v%0d_done", i), bus.done, 1);
        chk($sformatf("v%0d_err", i), bus.err, 0);
        chk($sformatf("v%0d_nwr_min", i), int'(wq.size() >= 1), 1);
        if (wq.size() >= 1) begin
          chk($sformatf("v%0d_a0", i), wq[0].addr, 0);
          chk($sformatf("v%0d_d0", i), wq[0].data, vecs[i].word);
        end
      end
    end

    // Overflow on the DEPTH=4 instance: four non-end words
    wq.delete(); wqs.delete();
    pulse_start();
    for (int w = 1; w <= 4; w++) begin
      send_byte(8'(w), 0);
      send_byte(8'h00, 0);
    end
    idle(3);
    chk("ovf_nwr", wqs.size(), 4);
    for (int k = 0; k < 4 && k < wqs.size(); k++) begin
      chk($sformatf("ovf_a%0d", k), wqs[k].addr, k);
      chk($sformatf("ovf_d%0d", k), wqs[k].data, k + 1);
    end
    chk("ovf_err", bus_s.err, 1);
    chk("ovf_done", bus_s.done, 0);
    chk("ovf_wc", bus_s.word_count, 4);
    chk("ovf_busy", bus_s.busy, 0);
    chk("big_still_busy", bus.busy, 1);
    chk("big_wc4", bus.word_count, 4);
    send_byte(8'hFF, 0);
    send_byte(8'h01, 0);
    idle(3);
    chk("ovf_no_more_wr", wqs.size(), 4);
    chk("ovf_wc_held", bus_s.word_count, 4);
    chk("big_done", bus.done, 1);
    chk("big_wc5", bus.word_count, 5);

    // End word landing on the last address of the DEPTH=4 instance
    wqs.delete();
    pulse_start();
    for (int w = 1; w <= 3; w++) begin
      send_byte(8'(w), 0);
      send_byte(8'h00, 0);
    end
    send_byte(8'hFF, 0);
    send_byte(8'h01, 0);
    idle(3);
    chk("last_done", bus_s.done, 1);
    chk("last_err", bus_s.err, 0);
    chk("last_wc", bus_s.word_count, 4);
    if (wqs.size() == 4) begin
      chk("last_a3", wqs[3].addr, 3);
      chk("last_d3", wqs[3].data, 9'h1FF);
    end else begin
      chk("last_nwr", wqs.size(), 4);
    end

    // Asynchronous reset while waiting for the high byte
    wq.delete();
    pulse_start();
    send_byte(8'h42, 0);
    send_byte(8'h01, 0);
    idle(1);
    send_byte(8'h77, 0);
    chk("pre_rst_busy", bus.busy, 1);
    in_byte = 8'h01;
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_wr_addr", bus.wr_addr, 0);
    chk("arst_wr_data", bus.wr_data, 0);
    chk("arst_wc", bus.word_count, 0);
    chk("arst_done_err", {bus.done, bus.err, bus.wr_en}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_nwr", wq.size(), 1);
    chk("post_rst_ready", bus.in_ready, 0);
    chk("post_rst_busy", bus.busy, 0);
    in_valid = 1'b0;

    // Start pulse in LO is ignored
    wq.delete();
    pulse_start();
    send_byte(8'h25, 0);
    send_byte(8'h01, 0);
    idle(2);
    chk("mid_wc", bus.word_count, 1);
    pulse_start();
    chk("ign_wc", bus.word_count, 1);
    chk("ign_busy", bus.busy, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h01, 0);
    idle(3);
    chk("ign_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("ign_a1", wq[1].addr, 1);
      chk("ign_d1", wq[1].data, 9'h1FF);
    end
    chk("ign_done", bus.done, 1);
    chk("ign_wc2", bus.word_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
